// File: rtl/d_cache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache, one 32-bit word per line.
// Optional feature macro: DCACHE_BYPASS_EN (honours cpu_data_uncached when defined).
module d_cache_direct_mapped #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  input  logic        cpu_data_uncached,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);
  localparam int TAG_W = 30 - INDEX_WIDTH;
  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT} state_e;

  state_e                  state_q, state_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_mem_q  [LINES];
  logic [31:0]             data_mem_q [LINES];

  logic                    wr_q, bypass_q, hit_q;
  logic [1:0]              size_q;
  logic [31:0]             addr_q, wdata_q;
  logic                    hit_pend_q;
  logic [31:0]             hit_data_q;

  logic                    bypass;
  logic [INDEX_WIDTH-1:0]  idx, idx_q;
  logic [TAG_W-1:0]        tag, tag_q;
  logic                    lookup_hit, accept, mem_done, cached_read_q;
  logic [3:0]              lane_q;

`ifdef DCACHE_BYPASS_EN
  assign bypass = cpu_data_uncached;
`else
  logic unused_uncached;
  assign unused_uncached = cpu_data_uncached;
  assign bypass          = 1'b0;
`endif

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_mask = 4'b0001 << off;
      2'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  assign idx           = cpu_data_addr[INDEX_WIDTH+1:2];
  assign tag           = cpu_data_addr[31:INDEX_WIDTH+2];
  assign idx_q         = addr_q[INDEX_WIDTH+1:2];
  assign tag_q         = addr_q[31:INDEX_WIDTH+2];
  assign lookup_hit    = valid_q[idx] && (tag_mem_q[idx] == tag) && !bypass;
  assign accept        = (state_q == IDLE) && cpu_data_req && !rst;
  assign cached_read_q = !wr_q && !bypass_q;
  assign lane_q        = lane_mask(size_q, addr_q[1:0]);
  // A response may arrive together with the address handshake; it completes the access.
  assign mem_done      = cache_data_data_ok &&
                         ((state_q == MWAIT) || ((state_q == MREQ) && cache_data_addr_ok));

  // NOTE: every output and next-state signal gets a default first so no latch is inferred.
  always_comb begin
    state_d          = state_q;
    cpu_data_addr_ok = 1'b0;
    cache_data_req   = 1'b0;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'd0;
    cache_data_addr  = 32'd0;
    cache_data_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        cpu_data_addr_ok = cpu_data_req && !rst;
        if (cpu_data_req && (cpu_data_wr || !lookup_hit)) state_d = MREQ;
      end
      MREQ: begin
        cache_data_req   = 1'b1;
        cache_data_wr    = wr_q;
        cache_data_size  = cached_read_q ? 2'd2 : size_q;
        cache_data_addr  = cached_read_q ? {addr_q[31:2], 2'b00} : addr_q;
        cache_data_wdata = wdata_q;
        if (cache_data_addr_ok) state_d = cache_data_data_ok ? IDLE : MWAIT;
      end
      MWAIT: begin
        if (cache_data_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_data_data_ok = hit_pend_q || mem_done;
  assign cpu_data_rdata   = hit_pend_q             ? hit_data_q       :
                            (mem_done && !wr_q)    ? cache_data_rdata : 32'd0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      wr_q       <= 1'b0;
      bypass_q   <= 1'b0;
      hit_q      <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      hit_pend_q <= 1'b0;
      hit_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      hit_pend_q <= accept && !cpu_data_wr && lookup_hit;
      if (accept) begin
        wr_q     <= cpu_data_wr;
        bypass_q <= bypass;
        hit_q    <= lookup_hit;
        size_q   <= cpu_data_size;
        addr_q   <= cpu_data_addr;
        wdata_q  <= cpu_data_wdata;
        if (!cpu_data_wr && lookup_hit) hit_data_q <= data_mem_q[idx];
      end
      if (mem_done && cached_read_q) valid_q[idx_q] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (mem_done && cached_read_q) begin
      tag_mem_q[idx_q]  <= tag_q;
      data_mem_q[idx_q] <= cache_data_rdata;
    end else if (mem_done && wr_q && hit_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_q[i]) data_mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_d_cache_direct_mapped.sv
// Directed bench for d_cache_direct_mapped with a sram-like memory responder.
module tb_d_cache_direct_mapped;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_data_req, cpu_data_wr, cpu_data_uncached;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic        cache_data_req, cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr, cache_data_wdata;
  logic [31:0] cache_data_rdata;
  logic        cache_data_addr_ok, cache_data_data_ok;

  d_cache_direct_mapped #(.INDEX_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr), .cpu_data_size(cpu_data_size),
    .cpu_data_addr(cpu_data_addr), .cpu_data_wdata(cpu_data_wdata),
    .cpu_data_uncached(cpu_data_uncached), .cpu_data_rdata(cpu_data_rdata),
    .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
    .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
    .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
    .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
    .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
  );

  always #5 clk = ~clk;

  typedef enum int {RSP_NORMAL, RSP_SAME, RSP_HANG} rsp_mode_e;

  int          test_cnt = 0;
  int          fail_cnt = 0;
  rsp_mode_e   rsp_mode = RSP_NORMAL;
  int          rsp_cnt  = 0;
  logic [31:0] last_addr, last_wdata;
  logic [1:0]  last_size;
  logic        last_wr;
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    return mem.exists(k) ? mem[k] : 32'd0;
  endfunction

  // Memory responder: accepts on the first cycle it sees a request, answers one cycle later
  // (or in the same cycle, or never, depending on rsp_mode).
  initial begin
    int          phase;
    logic [31:0] w;
    phase = 0;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata   = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        cache_data_addr_ok = 1'b0;
        cache_data_data_ok = 1'b0;
        cache_data_rdata   = 32'd0;
      end else begin
        case (phase)
          0: if (cache_data_req) begin
            rsp_cnt++;
            last_addr  = cache_data_addr;
            last_wr    = cache_data_wr;
            last_size  = cache_data_size;
            last_wdata = cache_data_wdata;
            cache_data_addr_ok = 1'b1;
            phase = (rsp_mode == RSP_HANG) ? 2 : 1;
          end
          1: cache_data_addr_ok = 1'b0;
          2: cache_data_addr_ok = 1'b0;
          default: begin
            cache_data_data_ok = 1'b0;
            cache_data_addr_ok = 1'b0;
            cache_data_rdata   = 32'd0;
            phase = 0;
          end
        endcase
        if ((phase == 1 && (rsp_mode == RSP_SAME || !cache_data_addr_ok))) begin
          if (last_wr) begin
            w = mem_rd(last_addr);
            case (last_size)
              2'd0:    w[8*last_addr[1:0] +: 8] = last_wdata[8*last_addr[1:0] +: 8];
              2'd1:    w[16*last_addr[1] +: 16] = last_wdata[16*last_addr[1] +: 16];
              default: w = last_wdata;
            endcase
            mem[{last_addr[31:2], 2'b00}] = w;
            cache_data_rdata = 32'd0;
          end else begin
            cache_data_rdata = mem_rd(last_addr);
          end
          cache_data_data_ok = 1'b1;
          phase = 3;
        end
      end
    end
  end

  task automatic cpu_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic unc,
                            output logic [31:0] rd, output int lat);
    logic seen;
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_size = size;
    cpu_data_addr = addr; cpu_data_wdata = wdata; cpu_data_uncached = unc;
    #1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (cpu_data_addr_ok) begin seen = 1'b1; break; end
      @(negedge clk); #1;
    end
    check("addr_ok_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    cpu_data_req = 1'b0;
    #1;
    lat = -1;
    rd  = 32'hxxxx_xxxx;
    for (int n = 1; n <= 20; n++) begin
      if (cpu_data_data_ok) begin lat = n; rd = cpu_data_rdata; break; end
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    check("data_ok_pulse", {31'd0, cpu_data_data_ok}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_creq"},   {31'd0, cache_data_req},     32'd0);
    check({tag, "_aok"},    {31'd0, cpu_data_addr_ok},   32'd0);
    check({tag, "_dok"},    {31'd0, cpu_data_data_ok},   32'd0);
    check({tag, "_rdata"},  cpu_data_rdata,              32'd0);
    check({tag, "_caddr"},  cache_data_addr,             32'd0);
    check({tag, "_cwdata"}, cache_data_wdata,            32'd0);
    check({tag, "_cwr"},    {31'd0, cache_data_wr},      32'd0);
    check({tag, "_csize"},  {30'd0, cache_data_size},    32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat, cnt0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat, cnt0;
    rst = 1'b1;
    cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'd0;
    cpu_data_addr = 32'd0; cpu_data_wdata = 32'd0; cpu_data_uncached = 1'b0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h500] = 32'hCAFEF00D;
    mem[32'h600] = 32'hA5A50F0F;
    mem[32'h300] = 32'h0BADC0DE;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("rst");
    rst = 1'b0;

    // Cold read miss: one word read downstream
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, rd, lat);
    check("miss_data", rd, 32'hDEADBEEF);
    check("miss_lat", lat, 2);
    check("miss_reqs", rsp_cnt, cnt0 + 1);
    check("miss_addr", last_addr, 32'h100);
    check("miss_size", {30'd0, last_size}, 32'd2);
    check("miss_wr", {31'd0, last_wr}, 32'd0);

    // Re-read hits in one cycle with no downstream traffic
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, rd, lat);
    check("hit_data", rd, 32'hDEADBEEF);
    check("hit_lat", lat, 1);
    check("hit_reqs", rsp_cnt, cnt0);

    // Byte write goes through and merges into the line
    cnt0 = rsp_cnt;
    cpu_access(1'b1, 2'd0, 32'h101, 32'hAAAAAAAA, 1'b0, rd, lat);
    check("bw_reqs", rsp_cnt, cnt0 + 1);
    check("bw_addr", last_addr, 32'h101);
    check("bw_size", {30'd0, last_size}, 32'd0);
    check("bw_wr", {31'd0, last_wr}, 32'd1);
    check("bw_wdata", last_wdata, 32'hAAAAAAAA);
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, rd, lat);
    check("bw_hit_data", rd, 32'hDEADAAEF);
    check("bw_hit_reqs", rsp_cnt, cnt0);

    // Upper half-word write
    cpu_access(1'b1, 2'd1, 32'h102, 32'h55555555, 1'b0, rd, lat);
    check("hw_size", {30'd0, last_size}, 32'd1);
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, rd, lat);
    check("hw_hit_data", rd, 32'h5555AAEF);
    check("hw_hit_lat", lat, 1);

    // Write miss does not allocate
    cpu_access(1'b1, 2'd2, 32'h204, 32'h11111111, 1'b0, rd, lat);
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h204, 32'd0, 1'b0, rd, lat);
    check("wmiss_reqs", rsp_cnt, cnt0 + 1);
    check("wmiss_data", rd, 32'h11111111);

    // Conflict: 0x500 evicts 0x100
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h500, 32'd0, 1'b0, rd, lat);
    check("conf_data", rd, 32'hCAFEF00D);
    check("conf_reqs", rsp_cnt, cnt0 + 1);
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, rd, lat);
    check("evict_reqs", rsp_cnt, cnt0 + 1);
    check("evict_data", rd, 32'h5555AAEF);

    // Cached byte read is fetched as an aligned word
    cpu_access(1'b0, 2'd0, 32'h603, 32'd0, 1'b0, rd, lat);
    check("bread_addr", last_addr, 32'h600);
    check("bread_size", {30'd0, last_size}, 32'd2);
    check("bread_data", rd, 32'hA5A50F0F);

    // Response in the same cycle as the address handshake
    rsp_mode = RSP_SAME;
    cpu_access(1'b0, 2'd2, 32'h300, 32'd0, 1'b0, rd, lat);
    check("same_data", rd, 32'h0BADC0DE);
    check("same_lat", lat, 1);
    rsp_mode = RSP_NORMAL;
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h300, 32'd0, 1'b0, rd, lat);
    check("same_refill_hit", rsp_cnt, cnt0);
    check("same_refill_data", rd, 32'h0BADC0DE);

    // Uncached access
    mem[32'h100] = 32'h12345678;
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h100, 32'd0, 1'b1, rd, lat);
`ifdef DCACHE_BYPASS_EN
    check("unc_data", rd, 32'h12345678);
    check("unc_reqs", rsp_cnt, cnt0 + 1);
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, rd, lat);
    check("unc_after_data", rd, 32'h5555AAEF);
    check("unc_after_reqs", rsp_cnt, cnt0);
`else
    check("unc_ignored_data", rd, 32'h5555AAEF);
    check("unc_ignored_reqs", rsp_cnt, cnt0);
`endif

    // Reset while waiting for the memory response
    rsp_mode = RSP_HANG;
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_size = 2'd2;
    cpu_data_addr = 32'h700; cpu_data_uncached = 1'b0;
    #1;
    check("hang_accept", {31'd0, cpu_data_addr_ok}, 32'd1);
    @(negedge clk);
    cpu_data_req = 1'b0;
    @(negedge clk);
    cpu_data_req = 1'b1; cpu_data_addr = 32'h100;
    #1;
    check("mwait_no_accept", {31'd0, cpu_data_addr_ok}, 32'd0);
    check("mwait_no_creq", {31'd0, cache_data_req}, 32'd0);
    check("mwait_no_dok", {31'd0, cpu_data_data_ok}, 32'd0);
    cpu_data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    rsp_mode = RSP_NORMAL;
    cnt0 = rsp_cnt;
    cpu_access(1'b0, 2'd2, 32'h100, 32'd0, 1'b0, rd, lat);
    check("postrst_reqs", rsp_cnt, cnt0 + 1);
    check("postrst_data", rd, 32'h12345678);
    check("postrst_lat", lat, 2);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
